// File: rtl/spike_encoder_if.sv
// rtl/spike_encoder_if.sv - pixel stream valid/ready handshake into spike_encoder
interface spike_encoder_if #(
  parameter int PIX_BITS = 8
);
  logic                pix_valid;
  logic [PIX_BITS-1:0] pix_data;
  logic                pix_ready;

  modport master (output pix_valid, output pix_data, input  pix_ready);
  modport slave  (input  pix_valid, input  pix_data, output pix_ready);
endinterface

// File: rtl/spike_encoder.sv
// rtl/spike_encoder.sv - latency-coded spike encoder: a 16-pixel volley becomes per-channel spike times
// Optional SPIKE_ENCODER_DBUF_EN: accept the next volley's pixels while the current volley runs.
module spike_encoder #(
  parameter int NUM_SPIKES  = 16,
  parameter int PIX_BITS    = 8,
  parameter int LOG_TP      = 3,
  parameter int TIME_PERIOD = 24,
  parameter int LOG_T       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  spike_encoder_if.slave                     pix,
  input  logic [PIX_BITS-1:0]                threshold,
  output logic [LOG_T:0]                     time_val,
  output logic [NUM_SPIKES*(LOG_TP+1)-1:0]   spike_times,
  output logic                               volley_start,
  output logic                               volley_done,
  output logic                               busy
);
  localparam int ENTRY_W   = LOG_TP + 1;
  localparam int WCNT_W    = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;
  localparam int LAST_CH_I = NUM_SPIKES - 1;
  localparam int TP_LAST_I = TIME_PERIOD - 1;
  localparam int ONE_I     = 1;

  localparam logic [WCNT_W-1:0]  LAST_CH  = LAST_CH_I[WCNT_W-1:0];
  localparam logic [WCNT_W-1:0]  WCNT_ONE = ONE_I[WCNT_W-1:0];
  localparam logic [LOG_T:0]     TP_LAST  = TP_LAST_I[LOG_T:0];
  localparam logic [LOG_T:0]     T_ONE    = ONE_I[LOG_T:0];
  localparam logic [ENTRY_W-1:0] NO_SPIKE = '1;

  typedef enum logic {LOAD, RUN} state_t;

  state_t                          state, state_next;
  logic [LOG_T:0]                  time_next;
  logic                            load_volley;
  logic                            idle_volley;

  logic [ENTRY_W-1:0]              shadow [NUM_SPIKES];
  logic [NUM_SPIKES*ENTRY_W-1:0]   shadow_flat;
  logic [WCNT_W-1:0]               wr_cnt;
  logic                            shadow_full;
  logic                            rdy_en;
  logic                            ready;
  logic                            accept;
  logic [PIX_BITS-1:0]             pix_inv;
  logic [ENTRY_W-1:0]              enc_entry;

  // rdy_en keeps pix_ready low until the first edge after reset is released
`ifdef SPIKE_ENCODER_DBUF_EN
  assign ready = rdy_en && !shadow_full;
`else
  assign ready = rdy_en && !shadow_full && !busy;
`endif

  assign pix.pix_ready = ready;
  assign accept        = pix.pix_valid && ready;

  // 2**PIX_BITS-1 - pix is the bitwise inverse; its top LOG_TP bits are the spike time
  assign pix_inv = ~pix.pix_data;

  always_comb begin
    enc_entry = NO_SPIKE;
    if (pix.pix_data >= threshold) begin
      enc_entry = {1'b0, pix_inv[PIX_BITS-1 -: LOG_TP]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt      <= '0;
      shadow_full <= 1'b0;
      rdy_en      <= 1'b0;
      for (int i = 0; i < NUM_SPIKES; i++) begin
        shadow[i] <= NO_SPIKE;
      end
    end else begin
      rdy_en <= 1'b1;
      if (load_volley) begin
        shadow_full <= 1'b0;
      end else if (accept && (wr_cnt == LAST_CH)) begin
        shadow_full <= 1'b1;
      end
      if (accept) begin
        shadow[wr_cnt] <= enc_entry;
        wr_cnt         <= (wr_cnt == LAST_CH) ? '0 : wr_cnt + WCNT_ONE;
      end
    end
  end

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      shadow_flat[i*ENTRY_W +: ENTRY_W] = shadow[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // LOAD parks time_val at the last slot so the downstream layer stays cleared
  always_comb begin
    state_next  = state;
    time_next   = time_val;
    load_volley = 1'b0;
    idle_volley = 1'b0;
    case (state)
      LOAD: begin
        time_next = TP_LAST;
        if (shadow_full) begin
          load_volley = 1'b1;
          time_next   = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (time_val == TP_LAST) begin
          if (shadow_full) begin
            load_volley = 1'b1;
            time_next   = '0;
          end else begin
            idle_volley = 1'b1;
            time_next   = TP_LAST;
            state_next  = LOAD;
          end
        end else begin
          time_next = time_val + T_ONE;
        end
      end
      default: begin
        state_next = LOAD;
        time_next  = TP_LAST;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_val    <= TP_LAST;
      spike_times <= '1;
    end else begin
      time_val <= time_next;
      if (load_volley) begin
        spike_times <= shadow_flat;
      end else if (idle_volley) begin
        spike_times <= '1;
      end
    end
  end

  assign busy         = (state == RUN);
  assign volley_start = busy && (time_val == '0);
  assign volley_done  = busy && (time_val == TP_LAST);

endmodule

// File: tb/tb_spike_encoder.sv
// tb/tb_spike_encoder.sv - self-checking bench for spike_encoder (table vectors, corner sequences, random soak)
module tb_spike_encoder;
  localparam int NS = 16;
  localparam int PB = 8;
  localparam int LTP = 3;
  localparam int TP = 24;
  localparam int LT = 4;
  localparam int EW = LTP + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PB-1:0]    threshold;
  logic [LT:0]      time_val;
  logic [NS*EW-1:0] spike_times;
  logic             volley_start;
  logic             volley_done;
  logic             busy;

  spike_encoder_if #(.PIX_BITS(PB)) pif ();

  spike_encoder #(
    .NUM_SPIKES(NS), .PIX_BITS(PB), .LOG_TP(LTP), .TIME_PERIOD(TP), .LOG_T(LT)
  ) dut (
    .clk(clk), .rst(rst), .pix(pif), .threshold(threshold),
    .time_val(time_val), .spike_times(spike_times),
    .volley_start(volley_start), .volley_done(volley_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending pixels as a queue, the active volley as an array
  logic [EW-1:0] pend [$];
  logic [EW-1:0] cur [NS];
  int            t_m;
  bit            run_m;
  bit            started_m;

  typedef struct {
    logic [PB-1:0] thr;
    logic [PB-1:0] pix;
    logic [EW-1:0] exp;
  } vec_t;

  vec_t vecs [NS];
  logic [EW-1:0] exp_list [NS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] encode(input logic [PB-1:0] p, input logic [PB-1:0] th);
    int t;
    if (p < th) return '1;
    t = (255 - int'(p)) / 32;
    return {1'b0, t[LTP-1:0]};
  endfunction

  function automatic bit exp_ready();
`ifdef SPIKE_ENCODER_DBUF_EN
    return started_m && (pend.size() < NS);
`else
    return started_m && (pend.size() < NS) && !run_m;
`endif
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int i = 0; i < NS; i++) cur[i] = '1;
    t_m = TP - 1;
    run_m = 1'b0;
    started_m = 1'b0;
  endtask

  task automatic take_volley();
    for (int i = 0; i < NS; i++) cur[i] = pend.pop_front();
  endtask

  task automatic model_step(input bit acc, input logic [PB-1:0] p, input logic [PB-1:0] th);
    if (rst) begin
      model_reset();
      return;
    end
    started_m = 1'b1;
    if (!run_m) begin
      if (pend.size() == NS) begin
        take_volley();
        run_m = 1'b1;
        t_m = 0;
      end
    end else if (t_m == TP - 1) begin
      if (pend.size() == NS) begin
        take_volley();
        t_m = 0;
      end else begin
        run_m = 1'b0;
        for (int i = 0; i < NS; i++) cur[i] = '1;
      end
    end else begin
      t_m++;
    end
    if (acc) pend.push_back(encode(p, th));
  endtask

  task automatic check_outputs();
    logic [NS*EW-1:0] exp_st;
    for (int i = 0; i < NS; i++) exp_st[i*EW +: EW] = cur[i];
    chk("time_val", time_val, t_m);
    chk("spike_times", spike_times, exp_st);
    chk("pix_ready", pif.pix_ready, exp_ready());
    chk("busy", busy, run_m);
    chk("volley_start", volley_start, run_m && (t_m == 0));
    chk("volley_done", volley_done, run_m && (t_m == TP - 1));
  endtask

  task automatic tick();
    bit acc;
    check_outputs();
    acc = pif.pix_valid && exp_ready();
    @(posedge clk);
    model_step(acc, pif.pix_data, threshold);
    @(negedge clk);
  endtask

  task automatic send_pixel(input logic [PB-1:0] p, input logic [PB-1:0] th);
    bit done;
    done = 1'b0;
    pif.pix_valid = 1'b1;
    pif.pix_data = p;
    threshold = th;
    for (int n = 0; n < 200 && !done; n++) begin
      done = exp_ready();
      tick();
    end
    chk("send_accepted", done, 1'b1);
    pif.pix_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_time_val"}, time_val, TP - 1);
    chk({tag, "_spike_times"}, spike_times, {(NS*EW){1'b1}});
    chk({tag, "_pix_ready"}, pif.pix_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_volley_start"}, volley_start, 1'b0);
    chk({tag, "_volley_done"}, volley_done, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_values(tag);
    tick();
    rst = 1'b0;
    tick();
    chk({tag, "_ready_after"}, pif.pix_ready, 1'b1);
  endtask

  // Loads 16 random pixels and checks the resulting volley channel by channel
  task automatic load_and_check(input string tag);
    logic [PB-1:0] p, th;
    for (int i = 0; i < NS; i++) begin
      p = PB'($urandom);
      th = PB'($urandom_range(0, 255));
      exp_list[i] = encode(p, th);
      send_pixel(p, th);
    end
    for (int n = 0; n < 60 && !(run_m && t_m == 0); n++) tick();
    chk({tag, "_volley_start"}, volley_start, 1'b1);
    for (int i = 0; i < NS; i++) chk({tag, "_chan"}, spike_times[i*EW +: EW], exp_list[i]);
  endtask

  initial begin
    int acc_run;
    pif.pix_valid = 1'b0;
    pif.pix_data = '0;
    threshold = '0;
    rst = 1'b1;
    model_reset();

    // Reset state and pix_ready release
    @(negedge clk);
    check_reset_values("reset");
    tick();
    rst = 1'b0;
    chk("ready_before_edge", pif.pix_ready, 1'b0);
    tick();
    chk("ready_first_edge", pif.pix_ready, 1'b1);
    chk("idle_time_val", time_val, TP - 1);

    // Table-driven encoding vectors, threshold changing per pixel
    vecs[0]  = '{8'd16,  8'd255, 4'b0000};
    vecs[1]  = '{8'd16,  8'd128, 4'b0011};
    vecs[2]  = '{8'd16,  8'd200, 4'b0001};
    vecs[3]  = '{8'd16,  8'd0,   4'b1111};
    vecs[4]  = '{8'd128, 8'd128, 4'b0011};
    vecs[5]  = '{8'd128, 8'd127, 4'b1111};
    vecs[6]  = '{8'd0,   8'd0,   4'b0111};
    vecs[7]  = '{8'd255, 8'd255, 4'b0000};
    vecs[8]  = '{8'd255, 8'd254, 4'b1111};
    vecs[9]  = '{8'd100, 8'd99,  4'b1111};
    vecs[10] = '{8'd100, 8'd100, 4'b0100};
    vecs[11] = '{8'd1,   8'd31,  4'b0111};
    vecs[12] = '{8'd1,   8'd32,  4'b0110};
    vecs[13] = '{8'd0,   8'd223, 4'b0001};
    vecs[14] = '{8'd0,   8'd224, 4'b0000};
    vecs[15] = '{8'd50,  8'd160, 4'b0010};
    for (int i = 0; i < NS; i++) send_pixel(vecs[i].pix, vecs[i].thr);
    chk("start_latency_c1", volley_start, 1'b0);
    threshold = 8'd255;
    tick();
    chk("start_latency_c2", volley_start, 1'b1);
    chk("start_time_val", time_val, 0);
    for (int i = 0; i < NS; i++) chk("table_chan", spike_times[i*EW +: EW], vecs[i].exp);

`ifdef SPIKE_ENCODER_DBUF_EN
    // Stream the next volley during RUN; swap must be gapless
    for (int i = 0; i < NS; i++) begin
      logic [PB-1:0] p, th;
      p = PB'($urandom);
      th = PB'($urandom_range(0, 255));
      exp_list[i] = encode(p, th);
      send_pixel(p, th);
    end
    for (int n = 0; n < 60 && !(run_m && t_m == TP - 1); n++) tick();
    chk("preswap_time_val", time_val, TP - 1);
    chk("preswap_ready", pif.pix_ready, 1'b0);
    tick();
    chk("swap_time_val", time_val, 0);
    chk("swap_volley_start", volley_start, 1'b1);
    for (int i = 0; i < NS; i++) chk("swap_chan", spike_times[i*EW +: EW], exp_list[i]);
`else
    // pix_valid held through RUN must not be accepted
    acc_run = 0;
    pif.pix_valid = 1'b1;
    pif.pix_data = 8'hAA;
    for (int n = 0; n < 60 && run_m; n++) begin
      if (busy && pif.pix_ready) acc_run++;
      tick();
    end
    pif.pix_valid = 1'b0;
    chk("run_accepts", acc_run, 0);
    chk("run_ended_busy", busy, 1'b0);
    load_and_check("reload");
`endif

    // Reset mid-volley at time_val==10
`ifdef SPIKE_ENCODER_DBUF_EN
    for (int i = 0; i < 5; i++) send_pixel(PB'($urandom), 8'd0);
`endif
    for (int n = 0; n < 60 && !(run_m && t_m == 10); n++) tick();
    chk("pre_reset_time_val", time_val, 10);
    pulse_reset("midvolley");

    // Reset mid-load with 5 pixels buffered
    for (int i = 0; i < 5; i++) send_pixel(PB'($urandom), 8'd0);
    pulse_reset("midload");
    load_and_check("clean");

    // Random soak with rare resets
    for (int n = 0; n < 800; n++) begin
      pif.pix_valid = ($urandom_range(0, 9) < 7);
      pif.pix_data = PB'($urandom);
      threshold = PB'($urandom_range(0, 255));
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      #1;
      tick();
    end
    rst = 1'b0;
    pif.pix_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
endmodule
